// File: rtl/div_unit.sv
// Multicycle signed restoring divider: one shift-subtract step per clock,
// with sign fix-up and divide-by-zero / overflow flagging after the last step.
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;
    logic             ovf;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b_in;
    logic [WIDTH:0]   trial;

    // The most negative operand keeps its own bit pattern here, which is its correct unsigned magnitude.
    assign abs_a    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b_in = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign trial    = {rem_q, quo_q[WIDTH-1]} - {1'b0, abs_b};

    assign data_resultRDY = (state == DONE);
    assign busy           = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            abs_b          <= '0;
            rem_q          <= '0;
            quo_q          <= '0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            div_zero       <= 1'b0;
            ovf            <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
        end else if (ctrl_DIV) begin
            // A start always wins, silently abandoning any operation in flight.
            state    <= RUN;
            cnt      <= '0;
            abs_b    <= abs_b_in;
            rem_q    <= '0;
            quo_q    <= abs_a;
            neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            neg_r    <= data_operandA[WIDTH-1];
            div_zero <= (data_operandB == '0);
            ovf      <= (data_operandA == MOST_NEG) && (data_operandB == '1);
        end else begin
            case (state)
                RUN: begin
                    if (!trial[WIDTH]) begin
                        rem_q <= trial[WIDTH-1:0];
                    end else begin
                        rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                    end
                    quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (div_zero || ovf) begin
                        data_result    <= '0;
                        data_remainder <= '0;
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= neg_q ? -quo_q : quo_q;
                        data_remainder <= neg_r ? -rem_q : rem_q;
                        data_exception <= 1'b0;
                    end
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard testbench for div_unit: expected results are queued at each start
// and compared whenever the divider raises data_resultRDY.
module tb_div_unit;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] rem;
        logic        exc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int check_count = 0;
    int error_count = 0;
    exp_t sb_queue[$];

    div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act !== exp) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic signed [31:0] a, input logic signed [31:0] b);
        exp_t e;
        if (b == 0 || (a == 32'sh8000_0000 && b == -32'sd1)) begin
            e = '{res: 32'h0, rem: 32'h0, exc: 1'b1};
        end else begin
            e = '{res: a / b, rem: a % b, exc: 1'b0};
        end
        return e;
    endfunction

    // Drive one start pulse at the next rising edge and queue its expected result.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        sb_queue.push_back(e);
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
    endtask

    task automatic waitResult(input string tag);
        int n;
        n = 0;
        while (n < 60) begin
            @(negedge clock);
            n++;
            if (data_resultRDY) break;
        end
        checkOutput(tag, n, 34);
    endtask

    // Scoreboard consumer: any ready pulse must match the oldest outstanding operation.
    always @(negedge clock) begin
        if (data_resultRDY) begin
            if (sb_queue.size() == 0) begin
                checkOutput("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_queue.pop_front();
                checkOutput("result", data_result, e.res);
                checkOutput("remainder", data_remainder, e.rem);
                checkOutput("exception", {31'd0, data_exception}, {31'd0, e.exc});
                checkOutput("busy_at_rdy", {31'd0, busy}, 32'd1);
            end
        end
    end

    initial begin
        int rdy_seen;
        logic [31:0] a, b;

        repeat (3) @(negedge clock);
        checkOutput("reset_result", data_result, 32'h0);
        checkOutput("reset_remainder", data_remainder, 32'h0);
        checkOutput("reset_exc", {31'd0, data_exception}, 32'd0);
        checkOutput("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        applyStimulus(32'd100, 32'd7, '{res: 32'd14, rem: 32'd2, exc: 1'b0});
        checkOutput("busy_running", {31'd0, busy}, 32'd1);
        waitResult("lat_100_7");
        applyStimulus(-32'sd100, 32'd7, '{res: 32'hFFFF_FFF2, rem: 32'hFFFF_FFFE, exc: 1'b0});
        waitResult("lat_m100_7");
        applyStimulus(32'd100, -32'sd7, '{res: 32'hFFFF_FFF2, rem: 32'd2, exc: 1'b0});
        waitResult("lat_100_m7");
        applyStimulus(32'd5, 32'd0, '{res: 32'd0, rem: 32'd0, exc: 1'b1});
        waitResult("lat_div0");
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, '{res: 32'd0, rem: 32'd0, exc: 1'b1});
        waitResult("lat_ovf");
        applyStimulus(32'h8000_0000, 32'd1, '{res: 32'h8000_0000, rem: 32'd0, exc: 1'b0});
        waitResult("lat_minint_1");
        @(negedge clock);
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("hold_result", data_result, 32'h8000_0000);

        applyStimulus(32'd50, 32'd5, '{res: 32'd10, rem: 32'd0, exc: 1'b0});
        repeat (10) @(negedge clock);
        sb_queue.delete();
        applyStimulus(32'd9, 32'd2, '{res: 32'd4, rem: 32'd1, exc: 1'b0});
        waitResult("lat_restart");

        applyStimulus(32'd1000, 32'd3, '{res: 32'd333, rem: 32'd1, exc: 1'b0});
        repeat (20) @(negedge clock);
        reset = 1'b1;
        #1;
        sb_queue.delete();
        checkOutput("abort_result", data_result, 32'h0);
        checkOutput("abort_remainder", data_remainder, 32'h0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        checkOutput("no_rdy_after_abort", rdy_seen, 0);

        for (int i = 0; i < 1500; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'($urandom_range(0, 16)) - 32'd8;
                1: a = 32'($urandom_range(0, 200)) - 32'd100;
                2: b = b >> $urandom_range(1, 31);
                default: ;
            endcase
            applyStimulus(a, b, model(a, b));
            waitResult("lat_random");
        end

        @(negedge clock);
        checkOutput("sb_empty", sb_queue.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
